sub_bytes_iter: RTL

Sequential, parametrised AES SubBytes/InvSubBytes engine for the 128-bit state. It substitutes `LANES` bytes per clock over `16/LANES` beats, so one S-box instance can be traded against throughput. A valid/ready handshake sits on each side, and a per-transaction mode bit selects the forward or the inverse S-box. It sits between AddRoundKey and ShiftRows (encrypt) or between InvShiftRows and AddRoundKey (decrypt) in the iterative round datapath.

---
 rtl/sub_bytes_iter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes / InvSubBytes engine: substitutes LANES bytes of the
// 128-bit state per clock, with valid/ready handshakes on input and output.
module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [127:0]       st_q, st_d, st_sub;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inv_q, inv_d;
  logic [3:0]         base;
  logic [7:0]         st_bytes [16];
  logic [3:0]         lane_idx [LANES];
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    logic [7:0] y;
    y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  assign base = 4'(int'(cnt_q) * LANES);

  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign st_bytes[gi] = st_q[127-8*gi -: 8];
    // Only the bytes belonging to the current beat take the S-box result.
    assign st_sub[127-8*gi -: 8] = (cnt_q == CNT_W'(gi / LANES)) ? lane_out[gi % LANES]
                                                                 : st_bytes[gi];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
    assign lane_idx[gi] = base + 4'(gi);
    assign lane_in[gi]  = st_bytes[lane_idx[gi]];
    assign lane_out[gi] = inv_q ? sbox_inv(lane_in[gi]) : sbox_fwd(lane_in[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        st_d = st_sub;
        if (cnt_q == CNT_W'(BEATS - 1)) state_d = DONE;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Consuming the result and loading the next state share one edge.
        if (out_ready) begin
          if (in_valid) begin
            st_d    = in_data;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = st_q;

endmodule
